// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - Multi-requester arbiter in front of a synchronous pattern ROM
//
// Purpose:
//   Several sequencers share one synchronous pattern ROM. Each cycle at most one
//   pending request is granted (combinationally), its address is driven to the
//   ROM, and the ROM data returned one cycle later is tagged by a one-hot
//   registered read-valid strobe for the winning requester.
//
// Configuration macro:
//   ROM_ARB_FIXED_PRIO_EN - when defined, the lowest asserted request index always
//   wins and no last-granted pointer exists. When undefined (default), round-robin
//   arbitration starting after the last granted index is used.
//
// Ports:
//   i_clk       - clock, all logic on rising edge
//   i_rst_n     - synchronous active-low reset
//   i_req       - per-requester read request, held until granted
//   i_addr      - packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   o_gnt       - one-hot combinational grant
//   o_rvalid    - one-hot registered read-data strobe, one cycle after grant
//   o_rdata     - shared read data, passed straight from i_rom_data
//   o_rom_addr  - address to the synchronous ROM (zero when no grant)
//   i_rom_data  - ROM data, valid one cycle after o_rom_addr

module rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [DATA_W-1:0]         i_rom_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   w_win;
    logic               w_any;
    logic               w_grant_ok;
    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] r_rvalid;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest asserted index is written last.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_win = PTR_W'(i);
                w_any = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] r_last;
    int               w_idx;

    // Candidates are r_last+1 .. r_last+NUM_REQ (mod NUM_REQ). Scanning the
    // offsets from farthest to nearest lets the nearest asserted one win.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_req[w_idx]) begin
                w_win = PTR_W'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    // Pointer moves only on a real grant; reset makes requester 0 first in line.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= PTR_W'(NUM_REQ - 1);
        end else if (w_any) begin
            r_last <= w_win;
        end
    end
`endif

    assign w_grant_ok = i_rst_n && w_any;

    always_comb begin
        w_gnt = '0;
        if (w_grant_ok) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        o_rom_addr = '0;
        if (w_grant_ok) begin
            o_rom_addr = i_addr[int'(w_win)*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt;
        end
    end

    // A read granted in the cycle before reset asserts would otherwise surface
    // during the reset cycle; masking with reset discards it.
    assign o_rvalid = i_rst_n ? r_rvalid : '0;
    assign o_gnt    = w_gnt;
    assign o_rdata  = i_rom_data;

endmodule
